// File: rtl/cic_integrator_chain.sv
// rtl/cic_integrator_chain.sv - N-stage pipelined CIC integrator with decimation strobe; CIC_INT_SYNC_CLR_EN adds clr_i
module cic_integrator_chain #(
    parameter int IW = 11,
    parameter int N  = 3,
    parameter int R  = 8,
    parameter int M  = 1,
    parameter int OW = IW + N * $clog2(R * M)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
`ifdef CIC_INT_SYNC_CLR_EN
    input  logic                   clr_i,
`endif
    input  logic                   en_i,
    input  logic [IW-1:0]          data_i,
    output logic                   valid_o,
    output logic [OW-1:0]          data_o,
    output logic [$clog2(R)-1:0]   phase_o
);

    localparam int PW = $clog2(R);
    localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

    logic [OW-1:0] acc_q [N];
    logic [OW-1:0] acc_d [N];
    logic [PW-1:0] phase_q, phase_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [OW-1:0] sample_ext;

    assign sample_ext = {{(OW - IW){data_i[IW-1]}}, data_i};

    // Each stage adds the pre-edge value of the previous stage, so the chain is
    // a register pipeline rather than a combinational ripple.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (en_i) begin
            acc_d[0] = acc_q[0] + sample_ext;
            for (int k = 1; k < N; k++) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
            if (phase_q == PHASE_LAST) begin
                phase_d = '0;
                data_d  = acc_d[N-1];
                valid_d = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
`ifdef CIC_INT_SYNC_CLR_EN
        if (clr_i) begin
            for (int k = 0; k < N; k++) begin
                acc_d[k] = '0;
            end
            phase_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= '0;
            end
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= acc_d[k];
            end
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign phase_o = phase_q;

endmodule
